// File: rtl/square_drawer.sv
// rtl/square_drawer.sv - Draws a SIZE x SIZE white square into a frame buffer, optionally erasing the previous one
//
// Purpose:
//   On a start request in IDLE, the requested top-left corner is clamped so the
//   square stays on screen. The block then streams one pixel write per cycle in
//   raster order. When SQUARE_DRAWER_ERASE_PREV_EN is defined and a square was
//   drawn before, it first blacks out that square (ERASE) and then draws the new
//   one (DRAW). A one-cycle done pulse follows the last pixel.
//
// Configuration macro:
//   SQUARE_DRAWER_ERASE_PREV_EN - when defined, the previous square is erased
//                                 before the new one is drawn.
//
// Ports:
//   clk          - sole clock, all state changes on posedge
//   reset        - synchronous active-low reset
//   start        - draw request, only sampled in IDLE
//   x_loc, y_loc - requested top-left corner (11 bits each)
//   x, y         - pixel address presented to the frame buffer
//   pixel_color  - 1 = draw (white), 0 = erase (black)
//   wr_en        - frame-buffer write strobe, one pixel per high cycle
//   busy         - high while erasing or drawing
//   done         - single-cycle completion pulse

module square_drawer #(
    parameter int SIZE     = 20,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] x_loc,
    input  logic [10:0] y_loc,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        pixel_color,
    output logic        wr_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0]  LAST  = 6'(SIZE - 1);
    localparam logic [10:0] X_MAX = 11'(SCREEN_W - SIZE);
    localparam logic [10:0] Y_MAX = 11'(SCREEN_H - SIZE);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cx;
    logic [5:0]  cy;
    logic [10:0] org_x;
    logic [10:0] org_y;
    logic [10:0] x_hold;
    logic [10:0] y_hold;
    logic [10:0] base_x;
    logic [10:0] base_y;
    logic [10:0] x_cur;
    logic [10:0] y_cur;
    logic        active;
    logic        last_pix;
    logic        erase_needed;

`ifdef SQUARE_DRAWER_ERASE_PREV_EN
    logic [10:0] old_x;
    logic [10:0] old_y;
    logic        prev_valid;
`endif

    assign active   = (state == ERASE) || (state == DRAW);
    assign last_pix = (cx == LAST) && (cy == LAST);

    // Erase is only meaningful once a square has actually been completed;
    // an aborted draw (reset) leaves nothing trustworthy to erase.
`ifdef SQUARE_DRAWER_ERASE_PREV_EN
    assign erase_needed = prev_valid;
`else
    assign erase_needed = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = erase_needed ? ERASE : DRAW;
            ERASE:   if (last_pix) state_nxt = DRAW;
            DRAW:    if (last_pix) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pixel address generation; erase walks the old origin, draw the new one.
    always_comb begin
        base_x = org_x;
        base_y = org_y;
`ifdef SQUARE_DRAWER_ERASE_PREV_EN
        if (state == ERASE) begin
            base_x = old_x;
            base_y = old_y;
        end
`endif
        x_cur = base_x + {5'd0, cx};
        y_cur = base_y + {5'd0, cy};
    end

    // Output logic
    always_comb begin
        wr_en       = active;
        pixel_color = (state == DRAW);
        busy        = active;
        done        = (state == DONE);
        // Outside the pixel phases the address holds the last emitted pixel.
        x           = active ? x_cur : x_hold;
        y           = active ? y_cur : y_hold;
    end

    // Datapath: origin latch, scan counters, address hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            cx     <= '0;
            cy     <= '0;
            org_x  <= '0;
            org_y  <= '0;
            x_hold <= '0;
            y_hold <= '0;
`ifdef SQUARE_DRAWER_ERASE_PREV_EN
            old_x      <= '0;
            old_y      <= '0;
            prev_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        org_x <= (x_loc > X_MAX) ? X_MAX : x_loc;
                        org_y <= (y_loc > Y_MAX) ? Y_MAX : y_loc;
`ifdef SQUARE_DRAWER_ERASE_PREV_EN
                        old_x <= org_x;
                        old_y <= org_y;
`endif
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                ERASE, DRAW: begin
                    x_hold <= x_cur;
                    y_hold <= y_cur;
                    // Raster scan: cx inner, cy outer; both wrap to 0 on the
                    // last pixel so the next phase starts cleanly.
                    if (cx == LAST) begin
                        cx <= '0;
                        cy <= (cy == LAST) ? 6'd0 : cy + 6'd1;
                    end else begin
                        cx <= cx + 6'd1;
                    end
`ifdef SQUARE_DRAWER_ERASE_PREV_EN
                    if ((state == DRAW) && last_pix) begin
                        prev_valid <= 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
